// File: rtl/fp_pre_normalization.sv
// fp_pre_normalization: FP32 add/sub operand classify, special-case resolve, swap and align (PRE_NORM_STICKY_EN adds a sticky bit to man_y)
module fp_pre_normalization #(
    parameter int FORMAT_LENGTH             = 32,
    parameter int EXPONENT_LENGTH           = 8,
    parameter int FRACTION_LENGTH           = 23,
    parameter int NORMALIZE_MANTISSA_LENGTH = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [EXPONENT_LENGTH-1:0]           exp_a,
    input  logic [EXPONENT_LENGTH-1:0]           exp_b,
    input  logic [FRACTION_LENGTH-1:0]           fra_a,
    input  logic [FRACTION_LENGTH-1:0]           fra_b,
    input  logic                                 sign_a,
    input  logic                                 sign_b,
    input  logic                                 add_sub,
    output logic [FORMAT_LENGTH-1:0]             special_result,
    output logic                                 enable,
    output logic [EXPONENT_LENGTH-1:0]           exp,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_x,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_y,
    output logic                                 sign,
    output logic                                 sign_x,
    output logic                                 sign_y
);
    localparam int E = EXPONENT_LENGTH;
    localparam int F = FRACTION_LENGTH;
    localparam int M = NORMALIZE_MANTISSA_LENGTH;
    localparam logic [E-1:0] MAN_W = E'(M);
    localparam logic [FORMAT_LENGTH-2:0] INF_MAG = {{E{1'b1}}, {F{1'b0}}};
    localparam logic [FORMAT_LENGTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [1:0] {ZERO = 2'b00, NAN = 2'b01, INF = 2'b10, NORMAL = 2'b11} cls_t;

    function automatic cls_t classify(input logic [E-1:0] e, input logic [F-1:0] f);
        return (e == '0) ? ZERO : (&e) ? ((f != '0) ? NAN : INF) : NORMAL;
    endfunction

    logic [FORMAT_LENGTH-1:0] special_result_d, special_result_q;
    logic                     enable_d, enable_q;
    logic [E-1:0]             exp_d, exp_q;
    logic [M-1:0]             man_x_d, man_x_q, man_y_d, man_y_q;
    logic                     sign_x_d, sign_x_q, sign_y_d, sign_y_q;
    logic                     sb, swap, far;
    cls_t                     cls_a, cls_b;
    logic [E-1:0]             exp_x, exp_y, diff;
    logic [F-1:0]             fra_x, fra_y;
    logic [2*M-1:0]           shift_full;

    always_comb begin
        sb         = sign_b ^ add_sub;
        cls_a      = classify(exp_a, fra_a);
        cls_b      = classify(exp_b, fra_b);
        swap       = {exp_b, fra_b} > {exp_a, fra_a};
        exp_x      = swap ? exp_b : exp_a;
        exp_y      = swap ? exp_a : exp_b;
        fra_x      = swap ? fra_b : fra_a;
        fra_y      = swap ? fra_a : fra_b;
        diff       = exp_x - exp_y;
        far        = diff >= MAN_W;
        // upper half is the aligned mantissa, lower half collects the bits shifted out
        shift_full = {1'b1, fra_y, {M{1'b0}}} >> diff;
        special_result_d = '0;
        enable_d   = 1'b0;
        exp_d      = '0;
        man_x_d    = '0;
        man_y_d    = '0;
        sign_x_d   = 1'b0;
        sign_y_d   = 1'b0;
        if (cls_a == NORMAL && cls_b == NORMAL) begin
            enable_d = 1'b1;
            exp_d    = exp_x;
            man_x_d  = {1'b1, fra_x};
`ifdef PRE_NORM_STICKY_EN
            man_y_d  = far ? M'(1) : (shift_full[2*M-1:M] | M'(|shift_full[M-1:0]));
`else
            man_y_d  = far ? '0 : shift_full[2*M-1:M];
`endif
            sign_x_d = swap ? sb : sign_a;
            sign_y_d = swap ? sign_a : sb;
        end else begin
            special_result_d =
                (cls_a == NAN || cls_b == NAN) ? QNAN :
                (cls_a == INF && cls_b == INF) ? ((sign_a == sb) ? {sign_a, INF_MAG} : QNAN) :
                (cls_a == INF)                 ? {sign_a, INF_MAG} :
                (cls_b == INF)                 ? {sb, INF_MAG} :
                (cls_a == ZERO && cls_b == ZERO) ? {sign_a & sb, {(FORMAT_LENGTH-1){1'b0}}} :
                (cls_a == ZERO)                ? {sb, exp_b, fra_b} :
                                                 {sign_a, exp_a, fra_a};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            special_result_q <= '0;
            enable_q         <= 1'b0;
            exp_q            <= '0;
            man_x_q          <= '0;
            man_y_q          <= '0;
            sign_x_q         <= 1'b0;
            sign_y_q         <= 1'b0;
        end else begin
            special_result_q <= special_result_d;
            enable_q         <= enable_d;
            exp_q            <= exp_d;
            man_x_q          <= man_x_d;
            man_y_q          <= man_y_d;
            sign_x_q         <= sign_x_d;
            sign_y_q         <= sign_y_d;
        end
    end

    assign special_result = special_result_q;
    assign enable         = enable_q;
    assign exp            = exp_q;
    assign man_x          = man_x_q;
    assign man_y          = man_y_q;
    assign sign           = sign_x_q;
    assign sign_x         = sign_x_q;
    assign sign_y         = sign_y_q;
endmodule

// File: tb/tb_fp_pre_normalization.sv
// tb_fp_pre_normalization: directed table, reset corners and random vectors against an arithmetic reference model
module tb_fp_pre_normalization;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  exp_a = '0, exp_b = '0;
    logic [22:0] fra_a = '0, fra_b = '0;
    logic        sign_a = 1'b0, sign_b = 1'b0, add_sub = 1'b0;
    logic [31:0] o_special;
    logic        o_enable, o_sign, o_sign_x, o_sign_y;
    logic [7:0]  o_exp;
    logic [23:0] o_man_x, o_man_y;
    logic [91:0] got;
    int          vectors = 0;
    int          miscompares = 0;

    fp_pre_normalization dut (
        .clk(clk), .rst(rst),
        .exp_a(exp_a), .exp_b(exp_b), .fra_a(fra_a), .fra_b(fra_b),
        .sign_a(sign_a), .sign_b(sign_b), .add_sub(add_sub),
        .special_result(o_special), .enable(o_enable), .exp(o_exp),
        .man_x(o_man_x), .man_y(o_man_y), .sign(o_sign),
        .sign_x(o_sign_x), .sign_y(o_sign_y)
    );

    always #5 clk = ~clk;
    assign got = {o_special, o_enable, o_exp, o_man_x, o_man_y, o_sign, o_sign_x, o_sign_y};

`ifdef PRE_NORM_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    function automatic logic [91:0] pk(input logic [31:0] sr, input logic en, input logic [7:0] e,
                                       input logic [23:0] mx, input logic [23:0] my,
                                       input logic s, input logic sx, input logic sy);
        return {sr, en, e, mx, my, s, sx, sy};
    endfunction

    function automatic logic [91:0] model(input logic [7:0] ea, input logic [22:0] fa, input logic sa,
                                          input logic [7:0] eb, input logic [22:0] fb, input logic sbi,
                                          input logic op);
        logic s2, sx, sy;
        bit za, zb, na, nb, ia, ib;
        int ma, mb, ex, ey, fx, fy, d;
        longint mv, q, rem;
        s2 = sbi ^ op;
        za = (ea == 0);
        zb = (eb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        if (na || nb) return pk(32'h7FC00000, 0, 0, 0, 0, 0, 0, 0);
        if (ia && ib) return pk((sa == s2) ? {sa, 31'h7F800000} : 32'h7FC00000, 0, 0, 0, 0, 0, 0, 0);
        if (ia) return pk({sa, 31'h7F800000}, 0, 0, 0, 0, 0, 0, 0);
        if (ib) return pk({s2, 31'h7F800000}, 0, 0, 0, 0, 0, 0, 0);
        if (za && zb) return pk({sa & s2, 31'h0}, 0, 0, 0, 0, 0, 0, 0);
        if (za) return pk({s2, eb, fb}, 0, 0, 0, 0, 0, 0, 0);
        if (zb) return pk({sa, ea, fa}, 0, 0, 0, 0, 0, 0, 0);
        ma = int'(ea) * (1 << 23) + int'(fa);
        mb = int'(eb) * (1 << 23) + int'(fb);
        if (mb > ma) begin
            ex = int'(eb); fx = int'(fb); sx = s2;
            ey = int'(ea); fy = int'(fa); sy = sa;
        end else begin
            ex = int'(ea); fx = int'(fa); sx = sa;
            ey = int'(eb); fy = int'(fb); sy = s2;
        end
        d  = ex - ey;
        mv = (64'sd1 << 23) + longint'(fy);
        if (d >= 24) begin
            q = 0; rem = 1;
        end else begin
            q = mv / (64'sd1 << d); rem = mv % (64'sd1 << d);
        end
        if (STICKY && rem != 0) q = q | 1;
        return pk(32'h0, 1, 8'(ex), 24'((1 << 23) + fx), 24'(q), sx, sx, sy);
    endfunction

    task automatic drive(input logic [7:0] ea, input logic [22:0] fa, input logic sa,
                         input logic [7:0] eb, input logic [22:0] fb, input logic sbi, input logic op);
        exp_a = ea; fra_a = fa; sign_a = sa;
        exp_b = eb; fra_b = fb; sign_b = sbi; add_sub = op;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [91:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s[%0d] got=%h want=%h", tag, idx, got, want);
        end
    endtask

    typedef struct {
        logic [7:0]  ea;
        logic [22:0] fa;
        logic        sa;
        logic [7:0]  eb;
        logic [22:0] fb;
        logic        sb;
        logic        op;
        logic [91:0] want;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{8'h00, 23'h0, 0, 8'h00, 23'h0, 0, 0, pk(32'h00000000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{8'h00, 23'h0, 0, 8'hFF, 23'h0, 0, 1, pk(32'hFF800000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{8'h00, 23'h0, 0, 8'hFF, 23'h0, 0, 0, pk(32'h7F800000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{8'h00, 23'h0, 0, 8'hFF, 23'h1, 0, 0, pk(32'h7FC00000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{8'hFF, 23'h1, 0, 8'hFF, 23'h0, 0, 0, pk(32'h7FC00000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{8'h7E, 23'h0, 0, 8'h7D, 23'h300000, 0, 0,
                    pk(32'h0, 1, 8'h7E, 24'h800000, 24'h580000, 0, 0, 0)};
        tbl[6]  = '{8'h7D, 23'h300000, 0, 8'h7E, 23'h0, 0, 1,
                    pk(32'h0, 1, 8'h7E, 24'h800000, 24'h580000, 1, 1, 0)};
        tbl[7]  = '{8'h01, 23'h200000, 0, 8'hFE, 23'h740000, 0, 1,
                    pk(32'h0, 1, 8'hFE, 24'hF40000, STICKY ? 24'h000001 : 24'h000000, 1, 1, 0)};
        tbl[8]  = '{8'hFF, 23'h0, 0, 8'hFF, 23'h0, 0, 1, pk(32'h7FC00000, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{8'h00, 23'h0, 0, 8'h80, 23'h1234, 0, 1, pk(32'hC0001234, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{8'h00, 23'h5, 0, 8'h3F, 23'h1, 0, 0, pk(32'h1F800001, 0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{8'h90, 23'h55, 0, 8'h90, 23'h55, 0, 1,
                    pk(32'h0, 1, 8'h90, 24'h800055, 24'h800055, 0, 0, 1)};

        exp_a = 8'h7E; exp_b = 8'h7D; fra_b = 23'h300000;
        @(posedge clk);
        #1;
        check("reset_hold", 0, '0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ea, tbl[i].fa, tbl[i].sa, tbl[i].eb, tbl[i].fb, tbl[i].sb, tbl[i].op);
            check("table", i, tbl[i].want);
        end

        drive(tbl[5].ea, tbl[5].fa, tbl[5].sa, tbl[5].eb, tbl[5].fb, tbl[5].sb, tbl[5].op);
        check("pre_rst", 0, tbl[5].want);
        #1 rst = 1'b1;
        #1 check("async_rst", 0, '0);
        drive(tbl[6].ea, tbl[6].fa, tbl[6].sa, tbl[6].eb, tbl[6].fb, tbl[6].sb, tbl[6].op);
        check("rst_held", 0, '0);
        rst = 1'b0;
        drive(tbl[6].ea, tbl[6].fa, tbl[6].sa, tbl[6].eb, tbl[6].fb, tbl[6].sb, tbl[6].op);
        check("post_rst", 0, tbl[6].want);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  ea, eb;
            logic [22:0] fa, fb;
            logic        sa, sbi, op;
            int          k;
            k  = $urandom_range(0, 9);
            ea = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(1, 254));
            k  = $urandom_range(0, 9);
            eb = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF :
                 (k < 6) ? 8'($urandom_range(1, 254)) :
                 8'(((int'(ea) + $urandom_range(0, 30) - 15) % 254 + 254) % 254 + 1);
            k  = $urandom_range(0, 5);
            fa = (k == 0) ? 23'h0 : (k == 1) ? 23'h1 : 23'($urandom);
            k  = $urandom_range(0, 5);
            fb = (k == 0) ? 23'h0 : (k == 1) ? fa : 23'($urandom);
            sa = 1'($urandom); sbi = 1'($urandom); op = 1'($urandom);
            drive(ea, fa, sa, eb, fb, sbi, op);
            check("random", i, model(ea, fa, sa, eb, fb, sbi, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
